// File: rtl/mem_arb_pkg.sv
// Shared types for the memory write-port arbiter: controller states and requester ids.
// Requester ids double as bit positions in the arbiter request vector (HOST=bit0, ENG=bit1).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        CLEARING = 2'd1,
        RUN      = 2'd2
    } arb_state_t;

    typedef enum logic {
        HOST = 1'b0,
        ENG  = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_bank_write_arbiter_rr_arb2.sv
// Two-input round-robin grant; combinational grant, last_grant moves only on a completed transfer.
// A lone requester always wins; on contention the requester that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output requester_t grant
);

    requester_t last_grant;

    // With no or both requests, point at the requester that is not last_grant.
    always_comb begin
        grant = (last_grant == HOST) ? ENG : HOST;
        if (req == 2'b01) begin
            grant = HOST;
        end else if (req == 2'b10) begin
            grant = ENG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ENG;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_bank_write_arbiter.sv
// Shares the memory write port between host and engine, runs the clear sweep after reset/clear_req.
// Write reaches mem_wea 1 cycle after handshake; both readies are held low outside RUN and on clear_req.
module mem_bank_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 512,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_WIDTH  = $clog2(NUM_BANKS),
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WDOG_CYCLES = NUM_BANKS * DEPTH + 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  wdog_err,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [BANK_WIDTH-1:0] host_bank,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  eng_valid,
    output logic                  eng_ready,
    input  logic [BANK_WIDTH-1:0] eng_bank,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_data,
    output logic                  mem_reset_mem,
    output logic                  mem_wea,
    output logic [BANK_WIDTH-1:0] mem_banka,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dia,
    input  logic                  mem_done
);

    localparam int                WDOG_W    = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    // Write-request payload; widths come from this instance's parameters.
    typedef struct packed {
        logic [BANK_WIDTH-1:0] bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    arb_state_t        state;
    logic [WDOG_W-1:0] wdog_cnt;
    requester_t        grant;
    wr_req_t           host_req;
    wr_req_t           eng_req;
    wr_req_t           wr_q;
    logic              grant_open;
    logic              host_xfer;
    logic              eng_xfer;
    logic              xfer;

    assign host_req = '{bank: host_bank, addr: host_addr, data: host_data};
    assign eng_req  = '{bank: eng_bank,  addr: eng_addr,  data: eng_data};

    // A clear request closes the grant window in the same cycle it arrives.
    assign grant_open = (state == RUN) && !clear_req;
    assign host_ready = grant_open && (grant == HOST);
    assign eng_ready  = grant_open && (grant == ENG);
    assign host_xfer  = host_valid && host_ready;
    assign eng_xfer   = eng_valid && eng_ready;
    assign xfer       = host_xfer || eng_xfer;

    assign busy      = (state != RUN);
    assign mem_banka = wr_q.bank;
    assign mem_addra = wr_q.addr;
    assign mem_dia   = wr_q.data;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({eng_valid, host_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= START;
            wdog_cnt      <= '0;
            mem_reset_mem <= 1'b0;
            clear_done    <= 1'b0;
            wdog_err      <= 1'b0;
            mem_wea       <= 1'b0;
            wr_q          <= '0;
        end else begin
            mem_reset_mem <= 1'b0;
            clear_done    <= 1'b0;
            mem_wea       <= xfer;
            if (xfer) begin
                wr_q <= host_xfer ? host_req : eng_req;
            end
            case (state)
                START: begin
                    mem_reset_mem <= 1'b1;
                    wdog_cnt      <= '0;
                    state         <= CLEARING;
                end
                CLEARING: begin
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (mem_done) begin
                        state      <= RUN;
                        clear_done <= 1'b1;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        state      <= RUN;
                        clear_done <= 1'b1;
                        wdog_err   <= 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state <= START;
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_write_arbiter.sv
// Directed + randomized bench for mem_bank_write_arbiter with a stub memory and a grant/write reference model.
module tb_mem_bank_write_arbiter;

    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int NB       = 2;
    localparam int BW       = 1;
    localparam int AW       = 2;
    localparam int WDOG     = NB * DEPTH + 8;
    localparam int DONE_DLY = NB * DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          busy;
    logic          clear_done;
    logic          wdog_err;
    logic          host_valid;
    logic          host_ready;
    logic [BW-1:0] host_bank;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          eng_valid;
    logic          eng_ready;
    logic [BW-1:0] eng_bank;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_data;
    logic          mem_reset_mem;
    logic          mem_wea;
    logic [BW-1:0] mem_banka;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dia;
    logic          mem_done;

    always #5 clk = ~clk;

    mem_bank_write_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_BANKS  (NB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear_req     (clear_req),
        .busy          (busy),
        .clear_done    (clear_done),
        .wdog_err      (wdog_err),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_bank     (host_bank),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .eng_valid     (eng_valid),
        .eng_ready     (eng_ready),
        .eng_bank      (eng_bank),
        .eng_addr      (eng_addr),
        .eng_data      (eng_data),
        .mem_reset_mem (mem_reset_mem),
        .mem_wea       (mem_wea),
        .mem_banka     (mem_banka),
        .mem_addra     (mem_addra),
        .mem_dia       (mem_dia),
        .mem_done      (mem_done)
    );

    // Stub memory: sweep starts on reset_mem and raises done after DONE_DLY cycles when enabled.
    bit stub_en = 1'b1;
    bit sweep;
    int scnt;
    always @(posedge clk) begin
        if (reset) begin
            sweep    <= 1'b0;
            scnt     <= 0;
            mem_done <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            if (mem_reset_mem) begin
                sweep <= 1'b1;
                scnt  <= 0;
            end else if (sweep) begin
                scnt <= scnt + 1;
                if (scnt == DONE_DLY - 1) begin
                    sweep    <= 1'b0;
                    mem_done <= stub_en;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            last_eng;
    bit            exp_wdog;
    logic [BW-1:0] held_bank;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        clear_req  = 1'b0;
        host_valid = 1'b0;
        eng_valid  = 1'b0;
        step();
        step();
        last_eng  = 1'b1;
        exp_wdog  = 1'b0;
        held_bank = '0;
        held_addr = '0;
        held_data = '0;
        check("rst_mem_reset_mem", 32'(mem_reset_mem), 32'(0));
        check("rst_mem_wea", 32'(mem_wea), 32'(0));
        check("rst_clear_done", 32'(clear_done), 32'(0));
        check("rst_wdog_err", 32'(wdog_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_mem_payload", 32'({mem_banka, mem_addra, mem_dia}), 32'(0));
        reset = 1'b0;
    endtask

    // Entered with the controller in START; returns in the cycle it reaches RUN.
    task automatic do_clear(input bit wd, input bit pulse);
        bit done_pend;
        bit seen;
        done_pend = 1'b0;
        seen      = 1'b0;
        for (int c = 1; c <= WDOG + 20 && !seen; c++) begin
            step();
            if (done_pend || (wd && c == WDOG + 1)) begin
                seen = 1'b1;
                if (wd) exp_wdog = 1'b1;
            end
            check("clr_mem_reset_mem", 32'(mem_reset_mem), 32'(c == 1));
            check("clr_clear_done", 32'(clear_done), 32'(seen));
            check("clr_busy", 32'(busy), 32'(!seen));
            check("clr_wdog_err", 32'(wdog_err), 32'(exp_wdog));
            check("clr_mem_wea", 32'(mem_wea), 32'(0));
            if (!seen) begin
                check("clr_host_ready", 32'(host_ready), 32'(0));
                check("clr_eng_ready", 32'(eng_ready), 32'(0));
            end
            done_pend = mem_done;
            clear_req = pulse && (c == 3 || c == 5);
        end
        clear_req = 1'b0;
        check("clr_completed", 32'(seen), 32'(1));
    endtask

    // One RUN cycle: compare accepted transfers against the round-robin rule, then the issued write.
    task automatic cyc(output bit hacc, output bit eacc);
        bit win_h;
        bit win_e;
        #1;
        win_h = 1'b0;
        win_e = 1'b0;
        if (!clear_req) begin
            if (host_valid && eng_valid) begin
                win_h = last_eng;
                win_e = !last_eng;
            end else begin
                win_h = host_valid;
                win_e = eng_valid;
            end
        end
        check("host_accept", 32'(host_valid & host_ready), 32'(win_h));
        check("eng_accept", 32'(eng_valid & eng_ready), 32'(win_e));
        if (win_h) begin
            held_bank = host_bank; held_addr = host_addr; held_data = host_data;
        end else if (win_e) begin
            held_bank = eng_bank; held_addr = eng_addr; held_data = eng_data;
        end
        step();
        check("mem_wea", 32'(mem_wea), 32'(win_h | win_e));
        check("mem_banka", 32'(mem_banka), 32'(held_bank));
        check("mem_addra", 32'(mem_addra), 32'(held_addr));
        check("mem_dia", 32'(mem_dia), 32'(held_data));
        if (win_h || win_e) last_eng = win_e;
        hacc = win_h;
        eacc = win_e;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit h;
        bit e;
        reset = 1'b1; clear_req = 1'b0;
        host_valid = 1'b0; host_bank = '0; host_addr = '0; host_data = '0;
        eng_valid  = 1'b0; eng_bank  = '0; eng_addr  = '0; eng_data  = '0;

        do_reset();
        do_clear(1'b0, 1'b0);

        // Both saturating: strict alternation starting with HOST
        host_valid = 1'b1; host_bank = 1'b1; host_addr = 2'd0; host_data = 8'h10;
        eng_valid  = 1'b1; eng_bank  = 1'b0; eng_addr  = 2'd1; eng_data  = 8'h20;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("sat_host_ready", 32'(host_ready), 32'(i % 2 == 0));
            check("sat_eng_ready", 32'(eng_ready), 32'(i % 2 == 1));
            cyc(h, e);
            if (h) begin host_data = host_data + 8'd1; host_addr = host_addr + 2'd1; end
            if (e) eng_data = eng_data + 8'd1;
        end
        host_valid = 1'b0;
        eng_valid  = 1'b0;

        // Single host write
        host_valid = 1'b1; host_bank = 1'b1; host_addr = 2'd2; host_data = 8'hA5;
        cyc(h, e);
        check("hostwr_dia", 32'(mem_dia), 32'h0000_00A5);
        check("hostwr_addra", 32'(mem_addra), 32'(2));
        host_valid = 1'b0;
        cyc(h, e);

        // clear_req in RUN with eng_valid held; host write issued just before it
        host_valid = 1'b1; host_bank = 1'b0; host_addr = 2'd3; host_data = 8'h5A;
        cyc(h, e);
        host_valid = 1'b0;
        eng_valid = 1'b1; eng_bank = 1'b1; eng_addr = 2'd1; eng_data = 8'hC3;
        clear_req = 1'b1;
        cyc(h, e);
        clear_req = 1'b0;
        check("clrreq_busy", 32'(busy), 32'(1));
        do_clear(1'b0, 1'b0);
        cyc(h, e);
        check("clrreq_eng_dia", 32'(mem_dia), 32'h0000_00C3);
        eng_valid = 1'b0;

        // clear_req pulses during CLEARING are merged
        clear_req = 1'b1;
        cyc(h, e);
        clear_req = 1'b0;
        do_clear(1'b0, 1'b1);
        step();
        check("merge_clear_done", 32'(clear_done), 32'(0));
        check("merge_mem_reset_mem", 32'(mem_reset_mem), 32'(0));

        // Watchdog expiry, then a normal clear keeps wdog_err sticky
        stub_en = 1'b0;
        clear_req = 1'b1;
        cyc(h, e);
        clear_req = 1'b0;
        do_clear(1'b1, 1'b0);
        stub_en = 1'b1;
        clear_req = 1'b1;
        cyc(h, e);
        clear_req = 1'b0;
        do_clear(1'b0, 1'b0);

        // Reset in the middle of a clear restarts cleanly and drops wdog_err
        clear_req = 1'b1;
        cyc(h, e);
        clear_req = 1'b0;
        step();
        step();
        step();
        do_reset();
        do_clear(1'b0, 1'b0);

        // Randomized traffic with occasional clears
        for (int n = 0; n < 300; n++) begin
            if (!host_valid && $urandom_range(1, 0) == 1) begin
                host_valid = 1'b1;
                host_bank  = 1'($urandom_range(1, 0));
                host_addr  = 2'($urandom_range(3, 0));
                host_data  = 8'($urandom_range(255, 0));
            end
            if (!eng_valid && $urandom_range(1, 0) == 1) begin
                eng_valid = 1'b1;
                eng_bank  = 1'($urandom_range(1, 0));
                eng_addr  = 2'($urandom_range(3, 0));
                eng_data  = 8'($urandom_range(255, 0));
            end
            clear_req = ($urandom_range(49, 0) == 0);
            cyc(h, e);
            if (h) host_valid = 1'b0;
            if (e) eng_valid = 1'b0;
            if (clear_req) begin
                clear_req = 1'b0;
                do_clear(1'b0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
